fib2axis_rxctrl: RTL
====================

// Module: fib2axis_rxctrl
// PURPOSE
//  RX counterpart of the AXIS TX bridge controller. Pops one frame byte count from the RX byte-count FIFO, then streams
//  ceil(bcnt/8) words from the RX data FIFO onto an AXI-Stream master (MAC RX side) with tkeep/tlast on the final beat.
//  Sits between the bridge RX FIFOs (read side) and the user AXIS sink. Uses a 2-entry output buffer for 1 beat/cycle.
// PARAMETERS
//  DATA_WIDTH  64     data FIFO / tdata width (fixed 64; tkeep is 8 bits)
//  BCNT_WIDTH  32     byte-count FIFO word width
//  MAX_BYTES   9600   frames with bcnt > MAX_BYTES are streamed but flagged with tuser on the last beat
// PORTS
//  rx_mac_aclk          in   1    single clock for all logic
//  reset                in   1    asynchronous, active-high reset
//  rd_rxwbcnt_fifo      in   BCNT_WIDTH  byte-count FIFO read data (valid 1 cycle after rdreq)
//  rxwbcnt_rdreq        out  1    byte-count FIFO read request
//  rxwbcnt_rdempty      in   1    byte-count FIFO empty
//  rd_rxdata_fifo       in   64   data FIFO read data (valid 1 cycle after rdreq)
//  rxdata_rdreq         out  1    data FIFO read request
//  rxdata_rdempty       in   1    data FIFO empty
//  rx_axis_mac_tdata    out  64   stream data
//  rx_axis_mac_tkeep    out  8    byte enables, LSB-first contiguous
//  rx_axis_mac_tvalid   out  1    stream valid
//  rx_axis_mac_tlast    out  1    last beat of frame
//  rx_axis_mac_tuser    out  1    frame error (oversize), last beat only
//  rx_axis_mac_tready   in   1    sink ready
//  frame_done           out  1    1-cycle pulse when last beat accepted
//  zero_len_err         out  1    1-cycle pulse when a bcnt of 0 is popped
//  frame_cnt            out  32   frames completed since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer empty, no read in flight. Reset mid-frame abandons the frame; FIFOs not flushed.
//  States (one-hot): IDLE, BCNT, LOAD, DATA, DONE.
//   IDLE: if !rxwbcnt_rdempty -> BCNT. BCNT: rxwbcnt_rdreq=1 for exactly this cycle -> LOAD.
//   LOAD: capture bcnt; words=(bcnt+7)>>3; last_keep = bcnt[2:0]==0 ? 8'hFF : (8'h01<<bcnt[2:0])-1;
//         oversize = bcnt>MAX_BYTES. bcnt==0: pulse zero_len_err, no data read -> IDLE. Else -> DATA.
//   DATA: rxdata_rdreq = !rxdata_rdempty && rd_left!=0 && (occupancy+inflight)<2, where occupancy counts
//         the output buffer after this cycle's pop; rd_left decrements per rdreq. Returned word written to buffer
//         next cycle with beat index; tkeep=8'hFF except last word (last_keep); tlast/tuser(oversize) on last word only.
//         -> DONE when last beat handshakes (tvalid&&tready&&tlast).
//   DONE: frame_done=1, frame_cnt+=1 -> IDLE. Next bcnt pop may begin the following cycle.
//  AXIS rules: tvalid=buffer non-empty; tdata/tkeep/tlast/tuser stable while tvalid&&!tready; no tvalid drop without handshake.
//  Latency: bcnt FIFO non-empty to first tvalid = 5 cycles (IDLE,BCNT,LOAD,rdreq,data capture) with data FIFO non-empty.
//  Throughput: 1 beat/cycle with tready=1 and data FIFO non-empty.
//  Data FIFO empty mid-frame: stall rdreq, tvalid drops after buffer drains; no error. Never rdreq when rdempty.
//  bcnt count only from popped frame; data words of next frame never read before DONE.
//  Simultaneous push/pop of buffer in same cycle allowed; occupancy never exceeds 2.
// TESTING
//  bcnt=64, 8 words D0..D7, tready=1 -> 8 back-to-back beats, tkeep=FF, tlast on D7, frame_done once, frame_cnt=1.
//  bcnt=61 -> 8 beats, last tkeep=8'h1F, tlast=1; bcnt=1 -> 1 beat tkeep=8'h01 tlast=1.
//  tready toggled 1/0 each cycle, bcnt=40 -> 5 beats, data held stable during stalls, rdreq never with 2 buffered.
//  bcnt=0 popped -> zero_len_err pulse, rxdata_rdreq stays 0, no tvalid; next frame bcnt=16 streams normally.
//  bcnt=MAX_BYTES+1 -> all words streamed, tuser=1 only on last beat; data FIFO empty 3 cycles mid-frame -> pause, no rdreq.
//  reset asserted mid-frame (beat 3 of 8) -> all outputs 0 same cycle, state IDLE after release.

Source files
------------

// File: rtl/fib2axis_rxctrl.sv
// fib2axis_rxctrl: pops one frame byte count, then streams ceil(bcnt/8) data FIFO words
// onto an AXI-Stream master through a 2-entry output buffer (1 beat/cycle).
module fib2axis_rxctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BCNT_WIDTH = 32,
  parameter int unsigned MAX_BYTES  = 9600
) (
  input  logic                    rx_mac_aclk,
  input  logic                    reset,
  input  logic [BCNT_WIDTH-1:0]   rd_rxwbcnt_fifo,
  output logic                    rxwbcnt_rdreq,
  input  logic                    rxwbcnt_rdempty,
  input  logic [DATA_WIDTH-1:0]   rd_rxdata_fifo,
  output logic                    rxdata_rdreq,
  input  logic                    rxdata_rdempty,
  output logic [DATA_WIDTH-1:0]   rx_axis_mac_tdata,
  output logic [DATA_WIDTH/8-1:0] rx_axis_mac_tkeep,
  output logic                    rx_axis_mac_tvalid,
  output logic                    rx_axis_mac_tlast,
  output logic                    rx_axis_mac_tuser,
  input  logic                    rx_axis_mac_tready,
  output logic                    frame_done,
  output logic                    zero_len_err,
  output logic [31:0]             frame_cnt
);
  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
  localparam int unsigned WORDS_W = BCNT_WIDTH - 2;
  localparam int unsigned RND_W   = BCNT_WIDTH + 1;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_BCNT = 5'b00010,
    S_LOAD = 5'b00100,
    S_DATA = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]     keep;
    logic                  last;
    logic                  user;
  } beat_t;

  state_e             state_q, state_d;
  logic [WORDS_W-1:0] rd_left_q, rd_left_d;
  logic [KEEP_W-1:0]  last_keep_q, last_keep_d;
  logic               oversize_q, oversize_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic [1:0]         occ_q, occ_d;
  beat_t              slot0_q, slot0_d, slot1_q, slot1_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [RND_W-1:0]   bcnt_round;
  logic [WORDS_W-1:0] words;
  logic [KEEP_W-1:0]  keep_calc;
  logic               pop;
  logic               rdreq;
  logic [1:0]         occ_after;
  beat_t              new_beat;

  // Byte count decode, valid while in LOAD
  assign bcnt_round = {1'b0, rd_rxwbcnt_fifo} + RND_W'(7);
  assign words      = WORDS_W'(bcnt_round >> 3);
  assign keep_calc  = (rd_rxwbcnt_fifo[2:0] == 3'd0) ? '1
                    : (KEEP_W'(1) << rd_rxwbcnt_fifo[2:0]) - KEEP_W'(1);

  // Read only while buffer plus in-flight word leaves room after this cycle's pop
  assign pop       = (occ_q != 2'd0) && rx_axis_mac_tready;
  assign occ_after = occ_q - 2'(pop);
  assign rdreq     = (state_q == S_DATA) && !rxdata_rdempty && (rd_left_q != '0)
                  && (({1'b0, occ_after} + 3'(inflight_q)) < 3'd2);

  always_comb begin
    state_d     = state_q;
    rd_left_d   = rd_left_q;
    last_keep_d = last_keep_q;
    oversize_d  = oversize_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      S_IDLE: if (!rxwbcnt_rdempty) state_d = S_BCNT;
      S_BCNT: state_d = S_LOAD;
      S_LOAD: begin
        rd_left_d   = words;
        last_keep_d = keep_calc;
        oversize_d  = rd_rxwbcnt_fifo > BCNT_WIDTH'(MAX_BYTES);
        state_d     = (rd_rxwbcnt_fifo == '0) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rdreq) rd_left_d = rd_left_q - WORDS_W'(1);
        if (pop && slot0_q.last) state_d = S_DONE;
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-slot buffer: slot0 is the head presented on the stream
  always_comb begin
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    new_beat.data   = rd_rxdata_fifo;
    new_beat.keep   = inflight_last_q ? last_keep_q : '1;
    new_beat.last   = inflight_last_q;
    new_beat.user   = inflight_last_q && oversize_q;
    if (pop) slot0_d = slot1_q;
    if (inflight_q) begin
      if (occ_after == 2'd0) slot0_d = new_beat;
      else                   slot1_d = new_beat;
    end
    occ_d           = occ_after + 2'(inflight_q);
    inflight_d      = rdreq;
    inflight_last_d = rdreq && (rd_left_q == WORDS_W'(1));
  end

  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rd_left_q       <= '0;
      last_keep_q     <= '0;
      oversize_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      slot0_q         <= '0;
      slot1_q         <= '0;
      frame_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      rd_left_q       <= rd_left_d;
      last_keep_q     <= last_keep_d;
      oversize_q      <= oversize_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      slot0_q         <= slot0_d;
      slot1_q         <= slot1_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign rxwbcnt_rdreq      = (state_q == S_BCNT);
  assign rxdata_rdreq       = rdreq;
  assign rx_axis_mac_tvalid = (occ_q != 2'd0);
  assign rx_axis_mac_tdata  = slot0_q.data;
  assign rx_axis_mac_tkeep  = slot0_q.keep;
  assign rx_axis_mac_tlast  = slot0_q.last;
  assign rx_axis_mac_tuser  = slot0_q.user;
  assign frame_done         = (state_q == S_DONE);
  assign zero_len_err       = (state_q == S_LOAD) && (rd_rxwbcnt_fifo == '0);
  assign frame_cnt          = frame_cnt_q;

endmodule
